// File: rtl/alert_pkg.sv
// Shared types and helpers for the alert blinker and its sibling input debouncer.
package alert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    function automatic int ms_to_cycles(int freq_hz, int ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/alert_blinker_if.sv
// Event-in / indicator-out bundle between the parking FSM and the board pins.
interface alert_blinker_if;
    logic trig_pulse;
    logic led_out;
    logic busy;
    logic dropped;

    modport master (output trig_pulse, input led_out, busy, dropped);
    modport slave  (input trig_pulse, output led_out, busy, dropped);
endinterface

// File: rtl/alert_blinker_phase_timer.sv
// Down-counting phase timer; done marks the last cycle of the loaded phase.
module phase_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] cnt;

    // load_val is phase length minus one, so cnt==0 is the final cycle
    assign done = enable && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/alert_blinker.sv
// Turns one-cycle event pulses into BLINKS on/off LED sequences, queueing extras.
module alert_blinker
    import alert_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int ON_MS       = 200,
    parameter int OFF_MS      = 200,
    parameter int BLINKS      = 3,
    parameter int PEND_MAX    = 3
) (
    input  logic            clk,
    input  logic            rst,
    alert_blinker_if.slave  bus
);

    localparam int ON_CYC  = ms_to_cycles(CLK_FREQ_HZ, ON_MS);
    localparam int OFF_CYC = ms_to_cycles(CLK_FREQ_HZ, OFF_MS);
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam int BW      = ($clog2(BLINKS + 1) < 1) ? 1 : $clog2(BLINKS + 1);
    localparam int PW      = ($clog2(PEND_MAX + 1) < 1) ? 1 : $clog2(PEND_MAX + 1);

    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYC - 1);

    state_t         state, state_n;
    logic [BW-1:0]  blink_cnt, blink_n;
    logic [PW-1:0]  pend, pend_n;
    logic           tmr_load, tmr_done, seq_end, drop_n;
    logic [TW-1:0]  tmr_val;
    logic           led_q, busy_q, drop_q;
    logic           trig;

    assign trig = bus.trig_pulse;

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (state != IDLE),
        .done     (tmr_done)
    );

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = ON_LD;
        blink_n  = blink_cnt;
        pend_n   = pend;
        drop_n   = 1'b0;
        seq_end  = 1'b0;

        case (state)
            IDLE: begin
                if (trig) begin
                    state_n  = ON;
                    tmr_load = 1'b1;
                    blink_n  = BW'(BLINKS - 1);
                end
            end
            ON: begin
                if (tmr_done) begin
                    state_n  = OFF;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LD;
                end
            end
            OFF: begin
                if (tmr_done) begin
                    if (blink_cnt != '0) begin
                        state_n  = ON;
                        tmr_load = 1'b1;
                        blink_n  = blink_cnt - 1'b1;
                    end else begin
                        seq_end = 1'b1;
                        if (pend != '0 || trig) begin
                            state_n  = ON;
                            tmr_load = 1'b1;
                            blink_n  = BW'(BLINKS - 1);
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // At sequence end a coincident trigger replaces the dequeued one, so pend holds
        if (seq_end) begin
            if (pend != '0 && !trig)
                pend_n = pend - 1'b1;
        end else if (trig && state != IDLE) begin
            if (pend < PW'(PEND_MAX))
                pend_n = pend + 1'b1;
            else
                drop_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            blink_cnt <= '0;
            pend      <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_n;
            blink_cnt <= blink_n;
            pend      <= pend_n;
            led_q     <= (state_n == ON);
            busy_q    <= (state_n != IDLE);
            drop_q    <= drop_n;
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = drop_q;

endmodule

// File: tb/tb_alert_blinker.sv
// Directed scenarios with per-cycle expected outputs checked by a scoreboard monitor.
module tb_alert_blinker;

    typedef struct {
        int   cyc;
        logic led;
        logic busy;
        logic drp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    alert_blinker_if bus();

    alert_blinker #(
        .CLK_FREQ_HZ (1000),
        .ON_MS       (2),
        .OFF_MS      (3),
        .BLINKS      (2),
        .PEND_MAX    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int trg[3];
    int led_r[8];
    int busy_r[4];
    int rst_c;
    int drp_c;
    string scn;

    function automatic bit in_led(int c);
        for (int i = 0; i < 4; i++)
            if (led_r[2*i] <= c && c <= led_r[2*i+1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_busy(int c);
        for (int i = 0; i < 2; i++)
            if (busy_r[2*i] <= c && c <= busy_r[2*i+1]) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: outputs are presented every cycle, so compare whenever an expectation waits
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.led_out !== e.led) begin
                errors++;
                $display("FAIL %s led_out cyc %0d: got %b want %b", scn, e.cyc, bus.led_out, e.led);
            end
            checks++;
            if (bus.busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy cyc %0d: got %b want %b", scn, e.cyc, bus.busy, e.busy);
            end
            checks++;
            if (bus.dropped !== e.drp) begin
                errors++;
                $display("FAIL %s dropped cyc %0d: got %b want %b", scn, e.cyc, bus.dropped, e.drp);
            end
        end
    end

    task automatic run_scn();
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.trig_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 36; c++) begin
            bus.trig_pulse = (c == trg[0] || c == trg[1] || c == trg[2]);
            rst = (c == rst_c);
            e.cyc  = c;
            e.led  = in_led(c);
            e.busy = in_busy(c);
            e.drp  = (c == drp_c);
            q.push_back(e);
            @(posedge clk); #1;
        end
        bus.trig_pulse = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        bus.trig_pulse = 1'b0;

        scn = "single";
        trg = '{10, -1, -1}; rst_c = -1; drp_c = -1;
        led_r  = '{11, 12, 16, 17, -1, -1, -1, -1};
        busy_r = '{11, 20, -1, -1};
        run_scn();

        scn = "queued";
        trg = '{10, 12, -1}; rst_c = -1; drp_c = -1;
        led_r  = '{11, 12, 16, 17, 21, 22, 26, 27};
        busy_r = '{11, 30, -1, -1};
        run_scn();

        scn = "overflow";
        trg = '{10, 12, 14}; rst_c = -1; drp_c = 15;
        led_r  = '{11, 12, 16, 17, 21, 22, 26, 27};
        busy_r = '{11, 30, -1, -1};
        run_scn();

        scn = "boundary";
        trg = '{10, 20, -1}; rst_c = -1; drp_c = -1;
        led_r  = '{11, 12, 16, 17, 21, 22, 26, 27};
        busy_r = '{11, 30, -1, -1};
        run_scn();

        scn = "reset_mid_on";
        trg = '{10, 20, -1}; rst_c = 16; drp_c = -1;
        led_r  = '{11, 12, 16, 16, 21, 22, 26, 27};
        busy_r = '{11, 16, 21, 30};
        run_scn();

        scn = "trig_with_rst";
        trg = '{5, -1, -1}; rst_c = 5; drp_c = -1;
        led_r  = '{-1, -1, -1, -1, -1, -1, -1, -1};
        busy_r = '{-1, -1, -1, -1};
        run_scn();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
